// File: rtl/slavefifo2b_mode_arbiter.sv
// Shares one FX3 slave-FIFO pin interface between stream-IN, stream-OUT and loopback requesters.
// Mode changes go through a filtered request, a quiesce wait on the old owner and a guard gap.
module slavefifo2b_mode_arbiter #(
   parameter int unsigned STABLE_CYCLES   = 8,
   parameter int unsigned GUARD_CYCLES    = 4,
   parameter int unsigned QUIESCE_TIMEOUT = 1024
) (
   input  logic        clk_100,
   input  logic        reset_,
   input  logic [1:0]  mode_req,
   input  logic        slwr_in_,
   input  logic        pktend_in_,
   input  logic [31:0] data_in_stream,
   input  logic        slrd_out_,
   input  logic        sloe_out_,
   input  logic        slrd_lb_,
   input  logic        sloe_lb_,
   input  logic        slwr_lb_,
   input  logic        lb_rd_sel,
   input  logic [31:0] data_lb,
   output logic        slrd_,
   output logic        sloe_,
   output logic        slwr_,
   output logic        pktend_,
   output logic [1:0]  faddr,
   output logic [31:0] data_out,
   output logic        data_oe,
   output logic        stream_in_mode_selected,
   output logic        stream_out_mode_selected,
   output logic        loopback_mode_selected,
   output logic [1:0]  mode_active,
   output logic        switch_busy,
   output logic        err_timeout
);

   localparam int unsigned FiltW  = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned GuardW = $clog2(GUARD_CYCLES + 1);
   localparam int unsigned ToW    = $clog2(QUIESCE_TIMEOUT + 1);

   localparam logic [FiltW-1:0]  FiltMax  = FiltW'(STABLE_CYCLES - 1);
   localparam logic [GuardW-1:0] GuardMax = GuardW'(GUARD_CYCLES - 1);
   localparam logic [ToW-1:0]    ToMax    = ToW'(QUIESCE_TIMEOUT - 1);

   localparam logic [1:0] ModeNone = 2'b00;
   localparam logic [1:0] ModeIn   = 2'b01;
   localparam logic [1:0] ModeOut  = 2'b10;
   localparam logic [1:0] ModeLb   = 2'b11;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StRun     = 2'd1;
   localparam logic [1:0] StQuiesce = 2'd2;
   localparam logic [1:0] StGuard   = 2'd3;

   logic [1:0]        mode_req_q, mode_req_d;
   logic [FiltW-1:0]  filt_cnt_q, filt_cnt_d;
   logic [1:0]        req_stable_q, req_stable_d;

   logic [1:0]        state_q, state_d;
   logic [1:0]        mode_active_q, mode_active_d;
   logic [2:0]        grant_q, grant_d;
   logic [GuardW-1:0] guard_cnt_q, guard_cnt_d;
   logic [ToW-1:0]    to_cnt_q, to_cnt_d;
   logic              quiet_q, quiet_d;
   logic              err_q, err_d;
   logic              old_quiet;

   function automatic logic [2:0] grant_of(input logic [1:0] mode);
      logic [2:0] g;
      g = 3'b000;
      unique case (mode)
         ModeIn:  g = 3'b001;
         ModeOut: g = 3'b010;
         ModeLb:  g = 3'b100;
         default: g = 3'b000;
      endcase
      return g;
   endfunction

   // A new sample restarts the count; the value is accepted once it has held long enough.
   always_comb begin
      mode_req_d   = mode_req;
      filt_cnt_d   = filt_cnt_q;
      req_stable_d = req_stable_q;
      if (mode_req != mode_req_q) begin
         filt_cnt_d = '0;
      end else if (filt_cnt_q == FiltMax) begin
         req_stable_d = mode_req_q;
      end else begin
         filt_cnt_d = filt_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         mode_req_q   <= ModeNone;
         filt_cnt_q   <= '0;
         req_stable_q <= ModeNone;
      end else begin
         mode_req_q   <= mode_req_d;
         filt_cnt_q   <= filt_cnt_d;
         req_stable_q <= req_stable_d;
      end
   end

   always_comb begin
      old_quiet = 1'b1;
      unique case (mode_active_q)
         ModeIn:  old_quiet = slwr_in_ & pktend_in_;
         ModeOut: old_quiet = slrd_out_ & sloe_out_;
         ModeLb:  old_quiet = slrd_lb_ & sloe_lb_ & slwr_lb_;
         default: old_quiet = 1'b1;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      mode_active_d = mode_active_q;
      grant_d       = grant_q;
      guard_cnt_d   = guard_cnt_q;
      to_cnt_d      = to_cnt_q;
      quiet_d       = 1'b0;
      err_d         = err_q;
      unique case (state_q)
         StIdle: begin
            grant_d = 3'b000;
            if (req_stable_q != ModeNone) begin
               state_d     = StGuard;
               guard_cnt_d = '0;
            end
         end
         StRun: begin
            if (req_stable_q != mode_active_q) begin
               state_d  = StQuiesce;
               grant_d  = 3'b000;
               to_cnt_d = '0;
            end
         end
         StQuiesce: begin
            quiet_d = old_quiet;
            // Two consecutive idle samples from the old owner before handing over.
            if (old_quiet && quiet_q) begin
               state_d     = StGuard;
               guard_cnt_d = '0;
            end else if (to_cnt_q == ToMax) begin
               err_d       = 1'b1;
               state_d     = StGuard;
               guard_cnt_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         StGuard: begin
            if (guard_cnt_q == GuardMax) begin
               if (req_stable_q == ModeNone) begin
                  state_d       = StIdle;
                  mode_active_d = ModeNone;
                  grant_d       = 3'b000;
               end else begin
                  state_d       = StRun;
                  mode_active_d = req_stable_q;
                  grant_d       = grant_of(req_stable_q);
               end
            end else begin
               guard_cnt_d = guard_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         state_q       <= StIdle;
         mode_active_q <= ModeNone;
         grant_q       <= 3'b000;
         guard_cnt_q   <= '0;
         to_cnt_q      <= '0;
         quiet_q       <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_active_q <= mode_active_d;
         grant_q       <= grant_d;
         guard_cnt_q   <= guard_cnt_d;
         to_cnt_q      <= to_cnt_d;
         quiet_q       <= quiet_d;
         err_q         <= err_d;
      end
   end

   // Pad mux is combinational so requester strobes reach the FX3 with no added latency.
   always_comb begin
      slrd_    = 1'b1;
      sloe_    = 1'b1;
      slwr_    = 1'b1;
      pktend_  = 1'b1;
      faddr    = 2'b00;
      data_out = '0;
      data_oe  = 1'b0;
      if (state_q == StRun || state_q == StQuiesce) begin
         unique case (mode_active_q)
            ModeIn: begin
               slwr_    = slwr_in_;
               pktend_  = pktend_in_;
               faddr    = 2'b00;
               data_out = data_in_stream;
               data_oe  = 1'b1;
            end
            ModeOut: begin
               slrd_ = slrd_out_;
               sloe_ = sloe_out_;
               faddr = 2'b11;
            end
            ModeLb: begin
               slrd_    = slrd_lb_;
               sloe_    = sloe_lb_;
               slwr_    = slwr_lb_;
               faddr    = lb_rd_sel ? 2'b11 : 2'b00;
               data_out = data_lb;
               data_oe  = ~lb_rd_sel;
            end
            default: ;
         endcase
      end
   end

   assign stream_in_mode_selected  = grant_q[0];
   assign stream_out_mode_selected = grant_q[1];
   assign loopback_mode_selected   = grant_q[2];
   assign mode_active              = mode_active_q;
   assign switch_busy              = (state_q == StQuiesce) || (state_q == StGuard);
   assign err_timeout              = err_q;

endmodule

// File: tb/tb_slavefifo2b_mode_arbiter.sv
// Self-checking bench for slavefifo2b_mode_arbiter: filter latency, muxing, quiesce/guard,
// quiesce timeout and asynchronous reset.
module tb_slavefifo2b_mode_arbiter;

   logic        clk_100 = 1'b0;
   logic        reset_;
   logic [1:0]  mode_req;
   logic        slwr_in_, pktend_in_;
   logic [31:0] data_in_stream;
   logic        slrd_out_, sloe_out_;
   logic        slrd_lb_, sloe_lb_, slwr_lb_, lb_rd_sel;
   logic [31:0] data_lb;
   logic        slrd_, sloe_, slwr_, pktend_;
   logic [1:0]  faddr;
   logic [31:0] data_out;
   logic        data_oe;
   logic        stream_in_mode_selected, stream_out_mode_selected, loopback_mode_selected;
   logic [1:0]  mode_active;
   logic        switch_busy, err_timeout;
   logic [2:0]  grants;
   logic [3:0]  strobes;

   int total = 0;
   int bad   = 0;

   always #5 clk_100 = ~clk_100;

   assign grants  = {loopback_mode_selected, stream_out_mode_selected, stream_in_mode_selected};
   assign strobes = {slrd_, sloe_, slwr_, pktend_};

   slavefifo2b_mode_arbiter dut (
      .clk_100                  (clk_100),
      .reset_                   (reset_),
      .mode_req                 (mode_req),
      .slwr_in_                 (slwr_in_),
      .pktend_in_               (pktend_in_),
      .data_in_stream           (data_in_stream),
      .slrd_out_                (slrd_out_),
      .sloe_out_                (sloe_out_),
      .slrd_lb_                 (slrd_lb_),
      .sloe_lb_                 (sloe_lb_),
      .slwr_lb_                 (slwr_lb_),
      .lb_rd_sel                (lb_rd_sel),
      .data_lb                  (data_lb),
      .slrd_                    (slrd_),
      .sloe_                    (sloe_),
      .slwr_                    (slwr_),
      .pktend_                  (pktend_),
      .faddr                    (faddr),
      .data_out                 (data_out),
      .data_oe                  (data_oe),
      .stream_in_mode_selected  (stream_in_mode_selected),
      .stream_out_mode_selected (stream_out_mode_selected),
      .loopback_mode_selected   (loopback_mode_selected),
      .mode_active              (mode_active),
      .switch_busy              (switch_busy),
      .err_timeout              (err_timeout)
   );

   typedef struct {
      logic        sel;
      logic        rd;
      logic        oe;
      logic        wr;
      logic [31:0] d;
      logic        in_low;
      logic [3:0]  exp_str;
      logic [1:0]  exp_faddr;
      logic        exp_oe;
      logic [31:0] exp_data;
   } vec_t;

   typedef struct {
      logic [3:0]  str;
      logic [1:0]  faddr;
      logic        oe;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_100);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic idle_inputs();
      slwr_in_  = 1'b1; pktend_in_ = 1'b1; data_in_stream = '0;
      slrd_out_ = 1'b1; sloe_out_  = 1'b1;
      slrd_lb_  = 1'b1; sloe_lb_   = 1'b1; slwr_lb_ = 1'b1;
      lb_rd_sel = 1'b0; data_lb    = '0;
   endtask

   task automatic wait_grant(input string name, input logic [2:0] g, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (grants == g) break;
         tick();
      end
      chk(name, grants, g);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[4];
      exp_t e;
      int   n;
      logic seen;

      // {sel, rd, oe, wr, data_lb, in_low} -> {slrd,sloe,slwr,pktend}, faddr, data_oe, data_out
      vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 4'b1101, 2'b00, 1'b1, 32'hA5A5_0001};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 4'b0011, 2'b11, 1'b0, 32'h1234_5678};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'b1011, 2'b11, 1'b0, 32'hDEAD_BEEF};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 4'b1111, 2'b00, 1'b1, 32'h0000_0000};

      idle_inputs();
      mode_req = 2'b00;
      reset_   = 1'b0;
      ticks(2);
      chk("rst_grants", grants, 3'b000);
      chk("rst_mode_active", mode_active, 2'b00);
      chk("rst_strobes", strobes, 4'hF);
      chk("rst_faddr", faddr, 2'b00);
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_data_oe", data_oe, 1'b0);
      chk("rst_busy", switch_busy, 1'b0);
      chk("rst_err", err_timeout, 1'b0);
      reset_ = 1'b1;
      ticks(2);

      // Short glitch must never reach the FSM.
      mode_req = 2'b01;
      slwr_in_ = 1'b0;
      ticks(3);
      mode_req = 2'b00;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (grants != 3'b000 || switch_busy || strobes != 4'hF) seen = 1'b1;
      end
      chk("glitch_idle", seen, 1'b0);
      slwr_in_ = 1'b1;

      // Filter latency (9) + idle decision (1) + guard (4).
      mode_req = 2'b11;
      ticks(13);
      chk("lb_before_grant", grants, 3'b000);
      chk("lb_guard_busy", switch_busy, 1'b1);
      chk("lb_guard_strobes", strobes, 4'hF);
      tick();
      chk("lb_grant", grants, 3'b100);
      chk("lb_mode_active", mode_active, 2'b11);
      chk("lb_busy_clear", switch_busy, 1'b0);

      for (int i = 0; i < 4; i++) begin
         lb_rd_sel = vecs[i].sel;
         slrd_lb_  = vecs[i].rd;
         sloe_lb_  = vecs[i].oe;
         slwr_lb_  = vecs[i].wr;
         data_lb   = vecs[i].d;
         slwr_in_  = ~vecs[i].in_low;
         pktend_in_ = ~vecs[i].in_low;
         sb_q.push_back('{vecs[i].exp_str, vecs[i].exp_faddr, vecs[i].exp_oe, vecs[i].exp_data});
         @(negedge clk_100);
         e = sb_q.pop_front();
         chk($sformatf("lb_vec%0d_strobes", i), strobes, e.str);
         chk($sformatf("lb_vec%0d_faddr", i), faddr, e.faddr);
         chk($sformatf("lb_vec%0d_data_oe", i), data_oe, e.oe);
         chk($sformatf("lb_vec%0d_data_out", i), data_out, e.data);
         tick();
      end
      idle_inputs();

      // Move to stream_in, then switch to stream_out while a write is in progress.
      mode_req = 2'b01;
      wait_grant("in_grant", 3'b001, 100);
      slwr_in_       = 1'b0;
      data_in_stream = 32'hCAFE_0001;
      @(negedge clk_100);
      chk("in_slwr", slwr_, 1'b0);
      chk("in_faddr", faddr, 2'b00);
      chk("in_data_oe", data_oe, 1'b1);
      chk("in_data_out", data_out, 32'hCAFE_0001);
      tick();
      mode_req = 2'b10;
      ticks(9);
      chk("sw_grant_held", grants, 3'b001);
      tick();
      chk("sw_grant_drop", grants, 3'b000);
      chk("sw_quiesce_busy", switch_busy, 1'b1);
      chk("sw_quiesce_slwr", slwr_, 1'b0);
      ticks(3);
      chk("sw_quiesce_slwr_held", slwr_, 1'b0);
      slwr_in_ = 1'b1;
      tick();
      chk("sw_quiet1_slwr", slwr_, 1'b1);
      chk("sw_quiet1_busy", switch_busy, 1'b1);
      slrd_out_ = 1'b0;
      chk("sw_quiet1_slrd_unsel", slrd_, 1'b1);
      tick();
      chk("sw_guard_slrd_forced", slrd_, 1'b1);
      chk("sw_guard_data_oe", data_oe, 1'b0);
      ticks(3);
      chk("sw_guard_end_grant", grants, 3'b000);
      chk("sw_guard_end_busy", switch_busy, 1'b1);
      tick();
      chk("out_grant", grants, 3'b010);
      chk("out_mode_active", mode_active, 2'b10);
      chk("out_faddr", faddr, 2'b11);
      chk("out_slrd", slrd_, 1'b0);
      chk("out_data_oe", data_oe, 1'b0);
      chk("out_busy", switch_busy, 1'b0);
      slrd_out_ = 1'b1;

      // Loopback owner stuck busy: quiesce times out.
      mode_req = 2'b11;
      wait_grant("lb2_grant", 3'b100, 100);
      slrd_lb_ = 1'b0;
      mode_req = 2'b00;
      for (int i = 0; i < 50; i++) begin
         if (switch_busy) break;
         tick();
      end
      chk("to_enter_quiesce", switch_busy, 1'b1);
      chk("to_quiesce_slrd", slrd_, 1'b0);
      chk("to_err_before", err_timeout, 1'b0);
      n = 0;
      while (!err_timeout && n < 1100) begin
         tick();
         n++;
      end
      chk("to_cycles", n, 1024);
      chk("to_err_set", err_timeout, 1'b1);
      chk("to_slrd_forced", slrd_, 1'b1);
      ticks(4);
      chk("to_idle_grants", grants, 3'b000);
      chk("to_idle_mode", mode_active, 2'b00);
      chk("to_idle_busy", switch_busy, 1'b0);
      slrd_lb_ = 1'b1;
      mode_req = 2'b01;
      wait_grant("to_next_grant", 3'b001, 100);
      chk("to_err_sticky", err_timeout, 1'b1);

      // Asynchronous reset in the middle of a write.
      slwr_in_   = 1'b0;
      pktend_in_ = 1'b0;
      @(negedge clk_100);
      chk("ar_slwr_active", slwr_, 1'b0);
      chk("ar_pktend_active", pktend_, 1'b0);
      #2;
      reset_ = 1'b0;
      #1;
      chk("ar_slwr", slwr_, 1'b1);
      chk("ar_pktend", pktend_, 1'b1);
      chk("ar_grants", grants, 3'b000);
      chk("ar_err_cleared", err_timeout, 1'b0);
      mode_req = 2'b00;
      idle_inputs();
      tick();
      reset_ = 1'b1;
      tick();
      chk("ar_post_grants", grants, 3'b000);
      chk("ar_post_mode", mode_active, 2'b00);
      chk("ar_post_busy", switch_busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
